load_store_unit: RTL and testbench

//  MEM-stage adapter between the pipeline and Data_Memory (word-wide, async read, word WE).

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/load_store_unit_lanes.sv | 45 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, RMW states
// and the byte-lane mask helper used by both the merge path and decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } lsu_state_t;

    // One bit per little-endian byte lane touched by an access of this size.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] mask;
        case (funct3)
            F3_B, F3_BU: mask = 4'b0001 << offset;
            F3_H, F3_HU: mask = offset[1] ? 4'b1100 : 4'b0011;
            F3_W:        mask = 4'b1111;
            default:     mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/load_store_unit_lanes.sv
// Combinational byte-lane datapath: extracts and extends a load lane from a memory
// word, and merges store data into that word for the read-modify-write path.
module byte_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted;
    logic [31:0] lane_src;
    logic [3:0]  mask;

    always_comb begin
        shifted = word_in >> {offset, 3'b000};
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'b0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'b0, shifted[15:0]};
            default: load_data = word_in;
        endcase
    end

    // Replicate the store data across lanes so the mask alone picks the target lane.
    always_comb begin
        mask = lane_mask(funct3, offset);
        case (funct3)
            F3_B, F3_BU: lane_src = {4{wdata[7:0]}};
            F3_H, F3_HU: lane_src = {2{wdata[15:0]}};
            default:     lane_src = wdata;
        endcase
        merge_data = word_in;
        for (int k = 0; k < 4; k++) begin
            if (mask[k]) begin
                merge_data[8*k +: 8] = lane_src[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage adapter to a word-wide async-read memory: sized loads, word stores,
// and byte/half stores performed as a two-cycle read-modify-write with busy stall.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              fault,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              fault_q, fault_d;
    logic              busy_q, busy_d;

    logic              illegal;
    logic [2:0]        lane_funct3;
    logic [1:0]        lane_offset;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    byte_lane_unit u_lanes (
        .word_in    (mem_rd),
        .wdata      (wdata_q),
        .funct3     (lane_funct3),
        .offset     (lane_offset),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        funct3_d      = funct3_q;
        wdata_d       = wdata_q;
        merge_d       = merge_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        fault_d       = 1'b0;
        mem_a         = {req_addr[ADDR_W-1:2], 2'b00};
        mem_wd        = req_wdata;
        mem_we        = 1'b0;
        lane_funct3   = req_funct3;
        lane_offset   = req_addr[1:0];

        case (req_funct3)
            F3_B:    illegal = 1'b0;
            F3_H:    illegal = req_addr[0];
            F3_W:    illegal = (req_addr[1:0] != 2'b00);
            F3_BU:   illegal = req_we;
            F3_HU:   illegal = req_we | req_addr[0];
            default: illegal = 1'b1;
        endcase

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        fault_d = 1'b1;
                    end else if (!req_we) begin
                        rdata_d       = load_data;
                        rdata_valid_d = 1'b1;
                    end else if (req_funct3 == F3_W) begin
                        mem_we = 1'b1;
                    end else begin
                        addr_d   = req_addr;
                        funct3_d = req_funct3;
                        wdata_d  = req_wdata;
                        state_d  = RMW_RD;
                    end
                end
            end
            RMW_RD: begin
                mem_a       = {addr_q[ADDR_W-1:2], 2'b00};
                lane_funct3 = funct3_q;
                lane_offset = addr_q[1:0];
                merge_d     = merge_data;
                state_d     = RMW_WR;
            end
            RMW_WR: begin
                mem_a   = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wd  = merge_q;
                mem_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset must suppress the write immediately, including an RMW_WR in flight.
        if (rst) begin
            mem_we = 1'b0;
            mem_a  = '0;
            mem_wd = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            funct3_q      <= '0;
            wdata_q       <= '0;
            merge_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            funct3_q      <= funct3_d;
            wdata_q       <= wdata_d;
            merge_q       <= merge_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            fault_q       <= fault_d;
            busy_q        <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a directed vector table, hand-built
// multi-cycle sequences, and random requests checked against a byte-level memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem_words [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_data;

    logic [7:0]  ref_mem [0:255];

    int          checks;
    int          failures;
    int          wr_count;
    int          rst_we_cnt;
    logic [31:0] last_wa;
    logic [31:0] last_wd;
    logic [31:0] exp_hold;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_fault;
        logic        exp_valid;
        logic [31:0] exp_rdata;
        int          exp_busy;
        int          exp_nwr;
        logic [31:0] exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[$];

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .busy        (busy),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .fault       (fault),
        .mem_a       (mem_a),
        .mem_wd      (mem_wd),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem_words[mem_a[7:2]];

    always @(posedge clk) begin
        if (poke_en) mem_words[poke_idx] <= poke_data;
        else if (mem_we) mem_words[mem_a[7:2]] <= mem_wd;
    end

    // Passive write monitor; the tasks only read these counters.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_count <= wr_count + 1;
            last_wa  <= mem_a;
            last_wd  <= mem_wd;
        end
        if (rst && mem_we) rst_we_cnt <= rst_we_cnt + 1;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit ref_fault(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = ref_size(f3);
        if (sz == 0) return 1'b1;
        if (we && f3[2]) return 1'b1;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        longint v;
        int     sz;
        sz = ref_size(f3);
        v  = 0;
        for (int i = 0; i < sz; i++) v += longint'(ref_mem[addr[7:0] + 8'(i)]) << (8 * i);
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v -= (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        return ref_load(3'b010, addr & 32'hFFFF_FFFC);
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        d = wdata;
        for (int i = 0; i < ref_size(f3); i++) ref_mem[addr[7:0] + 8'(i)] = d[8*i +: 8];
    endtask

    // ---------------- bench helpers ----------------
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke_word(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        poke_en   = 1'b1;
        poke_idx  = addr[7:2];
        poke_data = data;
        @(posedge clk); #1;
        poke_en = 1'b0;
        ref_store(3'b010, addr & 32'hFFFF_FFFC, data);
    endtask

    task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  output logic o_fault, output logic o_valid, output logic [31:0] o_rdata,
                                  output int o_busy, output int o_nwr,
                                  output logic [31:0] o_wa, output logic [31:0] o_wd);
        int wr0;
        @(posedge clk); #1;
        wr0        = wr_count;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        o_fault = fault;
        o_valid = rdata_valid;
        o_rdata = rdata;
        o_busy  = 0;
        while (busy && o_busy < 8) begin
            o_busy++;
            @(negedge clk);
        end
        o_nwr = wr_count - wr0;
        o_wa  = last_wa;
        o_wd  = last_wd;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        logic        f, vl;
        logic [31:0] rd, wa, wd;
        int          bc, nw;
        apply_stimulus(v.we, v.f3, v.addr, v.wdata, f, vl, rd, bc, nw, wa, wd);
        if (v.exp_valid) exp_hold = v.exp_rdata;
        check_output({tag, " fault"}, {31'b0, f}, {31'b0, v.exp_fault});
        check_output({tag, " rdata_valid"}, {31'b0, vl}, {31'b0, v.exp_valid});
        check_output({tag, " rdata"}, rd, exp_hold);
        check_output({tag, " busy_cycles"}, bc, v.exp_busy);
        check_output({tag, " writes"}, nw, v.exp_nwr);
        if (v.exp_nwr == 1 && nw == 1) begin
            check_output({tag, " mem_a"}, wa, v.exp_wa);
            check_output({tag, " mem_wd"}, wd, v.exp_wd);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ef, input logic ev,
                                input logic [31:0] er, input int eb, input int ew,
                                input logic [31:0] ewa, input logic [31:0] ewd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_fault = ef; v.exp_valid = ev; v.exp_rdata = er;
        v.exp_busy = eb; v.exp_nwr = ew; v.exp_wa = ewa; v.exp_wd = ewd;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int          k;
        int          wr0;
        bit          seen;
        vec_t        v;
        logic        f, vl;
        logic [31:0] rd, wa, wd, ea;
        int          bc, nw;

        checks     = 0;
        failures   = 0;
        wr_count   = 0;
        rst_we_cnt = 0;
        last_wa    = '0;
        last_wd    = '0;
        exp_hold   = '0;
        poke_en    = 1'b0;
        poke_idx   = '0;
        poke_data  = '0;
        for (int i = 0; i < 64; i++) mem_words[i] = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;

        // A word store is held on the request port during reset: it must not write.
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h14;
        req_wdata  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset busy", {31'b0, busy}, 32'd0);
        check_output("reset rdata_valid", {31'b0, rdata_valid}, 32'd0);
        check_output("reset fault", {31'b0, fault}, 32'd0);
        check_output("reset rdata", rdata, 32'd0);
        check_output("reset mem_we", {31'b0, mem_we}, 32'd0);
        check_output("reset mem_a", mem_a, 32'd0);
        check_output("reset mem_wd", mem_wd, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 1'b0;

        poke_word(32'h10, 32'h8899AABB);

        vecs.push_back(mk(0, 3'b000, 32'h13, 0, 0, 1, 32'hFFFFFF88, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b100, 32'h13, 0, 0, 1, 32'h00000088, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h12, 0, 0, 1, 32'hFFFF8899, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b101, 32'h10, 0, 0, 1, 32'h0000AABB, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h10, 0, 0, 1, 32'h8899AABB, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b000, 32'h11, 32'h123456CC, 0, 0, 0, 2, 1, 32'h10, 32'h8899CCBB));
        vecs.push_back(mk(0, 3'b010, 32'h10, 0, 0, 1, 32'h8899CCBB, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h12, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'h13, 32'h5555, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 32'h10, 32'h77, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b011, 32'h10, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b110, 32'h10, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b101, 32'h11, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 32'h14, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h14, 32'hDEADBEEF));
        vecs.push_back(mk(0, 3'b010, 32'h14, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b101, 32'h16, 0, 0, 1, 32'h0000DEAD, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h15, 0, 0, 1, 32'hFFFFFFBE, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b100, 32'h14, 0, 0, 1, 32'h000000EF, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'h16, 32'h0000F00D, 0, 0, 0, 2, 1, 32'h14, 32'hF00DBEEF));
        vecs.push_back(mk(0, 3'b010, 32'h14, 0, 0, 1, 32'hF00DBEEF, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_vec($sformatf("vec%0d", i), v);
            if (v.we && !v.exp_fault) ref_store(v.f3, v.addr, v.wdata);
        end
        check_output("no write under reset (table)", rst_we_cnt, 32'd0);

        // Reset during RMW_RD aborts the half-word store.
        poke_word(32'h10, 32'h8899AABB);
        @(posedge clk); #1;
        wr0        = wr_count;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h12;
        req_wdata  = 32'h0000BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check_output("rst-in-rd mem_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst-in-rd busy cleared", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check_output("rst-in-rd writes", wr_count - wr0, 32'd0);
        exp_hold = '0;
        run_vec("rst-in-rd reload", mk(0, 3'b010, 32'h10, 0, 0, 1, 32'h8899AABB, 0, 0, 0, 0));
        check_output("no write under reset (rd abort)", rst_we_cnt, 32'd0);

        // Byte store with a word load held behind it through the stall.
        @(posedge clk); #1;
        wr0        = wr_count;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h00000011;
        @(posedge clk); #1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 10) begin
            @(negedge clk);
            k++;
            if (rdata_valid) seen = 1'b1;
            else if (!busy && req_valid) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        ref_store(3'b000, 32'h10, 32'h11);
        exp_hold = 32'h8899AA11;
        check_output("b2b load seen", {31'b0, seen}, 32'd1);
        check_output("b2b load latency", k, 32'd4);
        check_output("b2b rdata", rdata, 32'h8899AA11);
        check_output("b2b writes", wr_count - wr0, 32'd1);
        check_output("b2b mem_a", last_wa, 32'h10);
        check_output("b2b mem_wd", last_wd, 32'h8899AA11);

        // Reset landing on RMW_WR must suppress the write itself.
        @(posedge clk); #1;
        wr0        = wr_count;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h12;
        req_wdata  = 32'h00000077;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("rst-in-wr mem_we", {31'b0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst-in-wr writes", wr_count - wr0, 32'd0);
        exp_hold = '0;
        run_vec("rst-in-wr reload", mk(0, 3'b010, 32'h10, 0, 0, 1, 32'h8899AA11, 0, 0, 0, 0));
        check_output("no write under reset (wr abort)", rst_we_cnt, 32'd0);

        // Random traffic over a private region, checked against the byte model.
        for (int i = 0; i < 8; i++) poke_word(32'h20 + 32'(4 * i), $urandom);
        for (int i = 0; i < 80; i++) begin
            v.we        = 1'($urandom_range(0, 1));
            v.f3        = 3'($urandom_range(0, 7));
            v.addr      = 32'h20 + 32'($urandom_range(0, 31));
            v.wdata     = $urandom;
            v.exp_fault = ref_fault(v.we, v.f3, v.addr);
            v.exp_valid = !v.exp_fault && !v.we;
            v.exp_rdata = v.exp_valid ? ref_load(v.f3, v.addr) : 32'h0;
            v.exp_busy  = (!v.exp_fault && v.we && ref_size(v.f3) < 4) ? 2 : 0;
            v.exp_nwr   = (!v.exp_fault && v.we) ? 1 : 0;
            ea          = v.addr & 32'hFFFF_FFFC;
            if (v.exp_nwr == 1) ref_store(v.f3, v.addr, v.wdata);
            v.exp_wa    = ea;
            v.exp_wd    = ref_word(ea);
            run_vec($sformatf("rnd%0d", i), v);
        end

        for (int i = 0; i < 8; i++) begin
            ea = 32'h20 + 32'(4 * i);
            apply_stimulus(1'b0, 3'b010, ea, 32'h0, f, vl, rd, bc, nw, wa, wd);
            check_output($sformatf("final word 0x%02h", ea), rd, ref_word(ea));
        end
        check_output("no write under reset (final)", rst_we_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
